// File: rtl/uart_tx_pkg.sv
// Shared UART types: transmitter state encoding, frame geometry and
// clock-divider settings used across the UART blocks.
package uart_tx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_BIT_CNT_W = $clog2(UART_DATA_BITS);

  // System clock (100 MHz) divided down to 115200 baud.
  localparam int unsigned CPU_CLK_DIV = 868;

  typedef enum logic [1:0] {
    UART_PREC_X1,
    UART_PREC_X8,
    UART_PREC_X16
  } uart_clk_precisision_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: frames one byte as start, 8 data bits (LSB first),
// optional even parity and 1 or 2 stop bits, paced by an external baud tick.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter bit          PARITY_EN = 1'b0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      baud_tick,
  input  logic [UART_DATA_BITS-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      tx,
  output logic                      busy
);

  localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST  = UART_BIT_CNT_W'(UART_DATA_BITS - 1);
  localparam logic                      STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_t              state_q, state_d;
  logic                        tx_q, tx_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                        stop_cnt_q, stop_cnt_d;
  logic                        accept;

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign tx       = tx_q;
  assign accept   = in_valid & in_ready;

  // Next-state and next-output logic; tx only moves on baud ticks.
  // The latched byte is indexed by the bit counter rather than shifted, so it
  // stays intact for the parity bit.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = in_data;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (baud_tick) begin
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (PARITY_EN) begin
              state_d = ST_PARITY;
              tx_d    = ^shift_q;
            end else begin
              state_d    = ST_STOP;
              tx_d       = 1'b1;
              stop_cnt_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[bit_cnt_d];
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d    = ST_IDLE;
            stop_cnt_d = '0;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover default framing,
// even parity and two stop bits, sharing clock, reset and baud tick.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick;
  logic [7:0] in_data = 8'h00;
  logic       in_valid0 = 1'b0, in_valid_p = 1'b0, in_valid_s = 1'b0;
  logic       in_ready0, in_ready_p, in_ready_s;
  logic       tx0, tx_p, tx_s;
  logic       busy0, busy_p, busy_s;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  always #5 clk = ~clk;

  // Baud tick every 4 clocks.
  int unsigned tick_cnt = 0;
  always @(posedge clk) tick_cnt <= (tick_cnt == 3) ? 0 : tick_cnt + 1;
  assign baud_tick = (tick_cnt == 3);

  uart_tx dut0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(in_valid0), .in_ready(in_ready0), .tx(tx0), .busy(busy0)
  );

  uart_tx #(.PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(in_valid_p), .in_ready(in_ready_p), .tx(tx_p), .busy(busy_p)
  );

  uart_tx #(.STOP_BITS(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .tx(tx_s), .busy(busy_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_tx();
    case (sel)
      0:       return tx0;
      1:       return tx_p;
      default: return tx_s;
    endcase
  endfunction

  function automatic logic cur_busy();
    case (sel)
      0:       return busy0;
      1:       return busy_p;
      default: return busy_s;
    endcase
  endfunction

  function automatic logic cur_ready();
    case (sel)
      0:       return in_ready0;
      1:       return in_ready_p;
      default: return in_ready_s;
    endcase
  endfunction

  task automatic set_valid(input logic v);
    case (sel)
      0:       in_valid0 = v;
      1:       in_valid_p = v;
      default: in_valid_s = v;
    endcase
  endtask

  // Wait for the next clock edge that carries a baud tick, sample tx just after it.
  task automatic tick_sample(output logic t);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (baud_tick) begin
        @(posedge clk);
        #1;
        got = 1;
      end
    end
    if (!got) check("tick_timeout", 0, 1);
    t = cur_tx();
  endtask

  task automatic collect(input int n, output logic [15:0] v);
    logic b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      tick_sample(b);
      v[i] = b;
    end
  endtask

  // Present one byte for a single accept; optionally line it up with a tick edge.
  task automatic send(input logic [7:0] d, input bit on_tick, input string tag);
    @(negedge clk);
    if (on_tick) begin
      for (int i = 0; i < 8 && !baud_tick; i++) @(negedge clk);
      check({tag, "_align"}, baud_tick, 1);
    end
    in_data = d;
    set_valid(1'b1);
    @(posedge clk);
    #1;
    set_valid(1'b0);
    check({tag, "_acc"}, cur_ready(), 0);
    check({tag, "_arm_tx"}, cur_tx(), 1);
  endtask

  // Accept log for dut0.
  int         n_acc0 = 0;
  logic [7:0] acc_log [16];
  always @(posedge clk) begin
    if (in_valid0 && in_ready0) begin
      if (n_acc0 < 16) acc_log[n_acc0] = in_data;
      n_acc0++;
    end
  end

  // tx must only move on tick edges while out of reset.
  always @(posedge clk) begin
    logic prev, tk, rn;
    prev = tx0;
    tk   = baud_tick;
    rn   = rst_n;
    #1;
    if (rn && rst_n && tx0 !== prev) check("tx_edge_tick", tk, 1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int          base;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx0", tx0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_ready0", in_ready0, 1);
    check("rst_tx_p", tx_p, 1);
    check("rst_ready_s", in_ready_s, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x55, no parity, one stop bit
    sel = 0;
    send(8'h55, 0, "f55");
    collect(10, v);
    check("f55_bits", v, 16'b1010101010);
    check("f55_busy_stop", busy0, 1);
    collect(1, v);
    check("f55_busy_end", busy0, 0);
    check("f55_ready_end", in_ready0, 1);

    // 0x07 with even parity
    sel = 1;
    send(8'h07, 0, "p07");
    collect(11, v);
    check("p07_bits", v, 16'b11000001110);
    check("p07_busy_stop", busy_p, 1);
    collect(1, v);
    check("p07_idle", busy_p, 0);

    // 0x00 with two stop bits
    sel = 2;
    send(8'h00, 0, "s00");
    collect(11, v);
    check("s00_bits", v, 16'b11000000000);
    check("s00_ready_2nd_stop", in_ready_s, 0);
    collect(1, v);
    check("s00_ready_end", in_ready_s, 1);
    check("s00_tx_end", tx_s, 1);

    // Back-to-back with in_valid held high
    sel  = 0;
    base = n_acc0;
    @(negedge clk);
    in_data   = 8'hA3;
    in_valid0 = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_acc1", in_ready0, 0);
    in_data = 8'h3C;
    collect(11, v);
    check("b2b_frame1", v, 16'b11101000110);
    check("b2b_gap_ready", in_ready0, 1);
    @(posedge clk);
    #1;
    check("b2b_acc2", in_ready0, 0);
    check("b2b_arm_tx", tx0, 1);
    in_valid0 = 1'b0;
    collect(10, v);
    check("b2b_frame2", v, 16'b1001111000);
    collect(1, v);
    check("b2b_idle", busy0, 0);
    check("b2b_acc_count", n_acc0 - base, 2);
    check("b2b_acc_first", acc_log[base], 8'hA3);
    check("b2b_acc_second", acc_log[base+1], 8'h3C);

    // Accept on a tick edge: that tick is not the start bit
    send(8'h01, 1, "coin");
    check("coin_busy", busy0, 1);
    collect(11, v);
    check("coin_bits", v, 16'b11000000010);
    check("coin_idle", busy0, 0);

    // Reset during data bit3, then a fresh 0xFF
    send(8'hC3, 0, "rst");
    collect(5, v);
    check("rst_pre_bits", v, 16'b00110);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx0, 1);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_ready", in_ready0, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'hFF, 0, "ff");
    collect(11, v);
    check("ff_bits", v, 16'b11111111110);
    check("ff_idle", busy0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
REQ-002 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port baud_tick  input  1  one-cycle baud enable pulse from uart_clk (uart_clk_out).
REQ-006 SHALL have port in_data  input  8  byte to transmit.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a byte.
REQ-009 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-010 SHALL have port busy  output  1  a frame is pending or in progress.

Function
REQ-011 SHALL accept a byte only on a clk edge where in_valid and in_ready are both 1, latching in_data into the shift register.
REQ-012 SHALL drive in_ready = 1 only in state IDLE, derived combinationally from the state.
REQ-013 SHALL implement the states IDLE, ARM, START, DATA, PARITY and STOP.
REQ-014 SHALL transition IDLE->ARM on accept; tx stays 1 while in ARM.
REQ-015 SHALL transition ARM->START on baud_tick and drive tx=0 on that same edge.
REQ-016 SHALL transition START->DATA on baud_tick and drive tx=bit0, with data sent LSB first.
REQ-017 SHALL, in DATA, output the next bit on each baud_tick using a 3-bit bit counter; on the tick that ends bit7, go to PARITY (if PARITY_EN) or to STOP.
REQ-018 SHALL, in PARITY, drive tx = XOR of the 8 data bits (even parity) for one tick interval, then go to STOP.
REQ-019 SHALL, in STOP, drive tx=1 for STOP_BITS tick intervals, then go to IDLE on the baud_tick that ends the last stop bit.
REQ-020 SHALL change tx only on edges where baud_tick=1, except at reset; every bit is therefore exactly one tick period long.
REQ-021 SHALL drive busy = 1 in every state except IDLE.
REQ-022 SHALL ignore baud_tick in IDLE.
REQ-023 SHALL, when accept and baud_tick coincide in IDLE, not count that tick; the start bit begins on the next baud_tick.
REQ-024 SHALL ignore in_valid while in_ready=0 and leave the latched byte unaltered; the upstream holds the data.
REQ-025 SHALL leave exactly one idle-high tick interval (ARM) between back-to-back frames in addition to the stop bits.
REQ-026 SHALL, for a frame with PARITY_EN=0 and STOP_BITS=1, produce 10 bit periods from the first start-bit tick to the return to IDLE.

Reset
REQ-027 SHALL, on rst_n low, immediately set state=IDLE, tx=1, shift register=0 and bit counter=0, so in_ready=1 and busy=0.
REQ-028 SHALL, on reset during a frame, abort the frame, take tx high within the reset assertion, and discard the frame without a retry.
REQ-029 SHALL, after reset deassertion, accept a new byte on the first qualifying edge.

Structure
REQ-030 SHALL take the uart_tx_state_t enum and UART_DATA_BITS=8 from the shared types package, next to CPU_CLK_DIV and uart_clk_precisision_t.
REQ-031 SHALL be a single module with no sub-modules; baud_tick comes from a separately instantiated uart_clk at the parent level.

Verification
REQ-032 SHALL pass this scenario: with a bench tick every 4 clk, send 0x55 (PARITY_EN=0) -> tx per tick reads 0,1,0,1,0,1,0,1,0,1, then idle; busy falls on the last stop tick.
REQ-033 SHALL pass this scenario: with PARITY_EN=1, send 0x07 -> start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1.
REQ-034 SHALL pass this scenario: with STOP_BITS=2, send 0x00 -> tx high for 2 tick periods after bit7, then in_ready=1.
REQ-035 SHALL pass this scenario: hold in_valid high with 0xA3 then 0x3C, back-to-back -> two frames separated by stop plus one idle-tick interval, each byte accepted exactly once.
REQ-036 SHALL pass this scenario: accept in the same cycle as baud_tick -> tx still 1 at that edge; start bit appears at the following tick.
REQ-037 SHALL pass this scenario: assert rst_n low during DATA bit3 -> tx=1, busy=0 and in_ready=1 immediately; a new byte 0xFF then transmits correctly.
